// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Iterative unsigned multiply / divide unit. An operation is accepted when
//   start is high while the unit is idle. It then runs for exactly WIDTH
//   clock edges, one shift-add or restore-divide step per edge, and
//   finishes with a one-cycle done pulse.
//
// Parameters
//   WIDTH        operand and result width
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   start        request strobe, honoured only while busy = 0
//   op           00 MUL (low word), 01 MULHU (high word),
//                10 DIVU (quotient), 11 REMU (remainder)
//   A            multiplicand / dividend
//   B            multiplier / divisor
//   busy         high while an operation iterates
//   done         one-cycle pulse; Out and div_by_zero are valid with it
//   Out          result, held until the next done pulse
//   div_by_zero  set with done for DIVU/REMU when B was zero
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Out,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             finish;

    // Latched operands and operation
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;

    // Shared working registers.
    //   Multiply: {work_hi, work_lo} is the 2*WIDTH-bit accumulator; work_lo
    //             starts as the multiplier and is consumed LSB first.
    //   Divide:   work_hi is the partial remainder, work_lo starts as the
    //             dividend (consumed MSB first) and fills with quotient bits.
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    // One-step next values
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             b_zero;
    logic [WIDTH-1:0] result;
    logic             result_dbz;

    assign busy = (state_q == RUN);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Iteration datapath (combinational single step)
    // ------------------------------------------------------------------
    always_comb begin
        // Shift-add: conditionally add the multiplicand to the upper half,
        // then shift the whole accumulator right by one, carry included.
        mul_sum = work_lo[0] ? ({1'b0, work_hi} + {1'b0, a_q})
                             : {1'b0, work_hi};

        // Restoring divide with a WIDTH+1-bit subtractor. Because the
        // partial remainder is always below a non-zero divisor, the shifted
        // value is below 2*B, so bit WIDTH of the difference is exactly the
        // borrow. With B = 0 the quotient/remainder are overridden below.
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = ~div_diff[WIDTH];

        step_hi = work_hi;
        step_lo = work_lo;
        if (op_q[1]) begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Result selection, valid on the final iteration
    // ------------------------------------------------------------------
    always_comb begin
        b_zero     = (b_q == '0);
        result     = '0;
        result_dbz = 1'b0;
        case (op_q)
            OP_MUL:   result = step_lo;
            OP_MULHU: result = step_hi;
            OP_DIVU: begin
                result     = b_zero ? '1 : step_lo;
                result_dbz = b_zero;
            end
            OP_REMU: begin
                result     = b_zero ? a_q : step_hi;
                result_dbz = b_zero;
            end
            default: result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iteration counter: cleared on accept, stops at WIDTH-1
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (busy && !finish) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Operand latch and working registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= op;
            if (op[1]) begin
                work_hi <= '0;
                work_lo <= A;
            end else begin
                work_hi <= '0;
                work_lo <= B;
            end
        end else if (busy) begin
            work_hi <= step_hi;
            work_lo <= step_lo;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            done        <= 1'b0;
            Out         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                Out         <= result;
                div_by_zero <= result_dbz;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//   Self-checking bench for mul_div_unit (WIDTH = 32). A vector table and a
//   few hand-written sequences drive operations; expected results are queued
//   when an operation is issued and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Out;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] out;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [W-1:0] out;
        logic         dbz;
        int           e0;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[$];

    mul_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .Out        (Out),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic z);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        z = 1'b0;
        case (o)
            2'b00: r = p[W-1:0];
            2'b01: r = p[2*W-1:W];
            2'b10: begin r = (b == 0) ? '1 : a / b; z = (b == 0); end
            default: begin r = (b == 0) ? a : a % b; z = (b == 0); end
        endcase
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest request and
    // arrive exactly W edges after that request was accepted.
    always @(negedge clk) begin
        if (done) begin
            sb_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                chk("done_without_request", {63'b0, done}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out", {32'b0, Out}, {32'b0, e.out});
                chk("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dbz});
                chk("latency", 64'(cyc - e.e0), 64'(W));
            end
        end
    end

    // Called #1 after a rising edge; start is seen by the next edge (E0).
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit push,
                         input logic [W-1:0] exp, input logic expz);
        sb_t e;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (push) begin
            e.out = exp;
            e.dbz = expz;
            e.e0  = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        op    = 2'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("pending_after_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [W-1:0] r;
        logic         z;
        int           e0;
        int           d0;

        vecs.push_back('{2'b00, 32'd7,          32'd6,          32'h0000002A, 1'b0});
        vecs.push_back('{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 1'b0});
        vecs.push_back('{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 1'b0});
        vecs.push_back('{2'b10, 32'd100,        32'd7,          32'd14,       1'b0});
        vecs.push_back('{2'b11, 32'd100,        32'd7,          32'd2,        1'b0});
        vecs.push_back('{2'b10, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 1'b0});
        vecs.push_back('{2'b10, 32'd5,          32'd0,          32'hFFFFFFFF, 1'b1});
        vecs.push_back('{2'b11, 32'd5,          32'd0,          32'd5,        1'b1});
        vecs.push_back('{2'b01, 32'h80000000,   32'd4,          32'd2,        1'b0});
        vecs.push_back('{2'b00, 32'h80000000,   32'd4,          32'd0,        1'b0});
        vecs.push_back('{2'b10, 32'h80000000,   32'h80000000,   32'd1,        1'b0});
        vecs.push_back('{2'b11, 32'hFFFFFFFF,   32'h00000010,   32'h0000000F, 1'b0});
        vecs.push_back('{2'b10, 32'd3,          32'd5,          32'd0,        1'b0});
        vecs.push_back('{2'b11, 32'd3,          32'd5,          32'd3,        1'b0});
        vecs.push_back('{2'b00, 32'd0,          32'hDEADBEEF,   32'd0,        1'b0});

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        A     = '0;
        B     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_out", {32'b0, Out}, 64'd0);
        chk("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table vectors, then hold/pulse-width checks after each
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].out, vecs[i].dbz);
            chk("busy_running", {63'b0, busy}, 64'd1);
            wait_idle();
            repeat (2) @(negedge clk);
            chk("hold_out", {32'b0, Out}, {32'b0, vecs[i].out});
            chk("hold_dbz", {63'b0, div_by_zero}, {63'b0, vecs[i].dbz});
            chk("done_one_cycle", {63'b0, done}, 64'd0);
            @(posedge clk);
            #1;
        end

        // Random operations against the arithmetic model
        for (int i = 0; i < 10; i++) begin
            logic [1:0]   o;
            logic [W-1:0] a;
            logic [W-1:0] b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 3 == 0) ? W'($urandom_range(0, 15)) : $urandom;
            model(o, a, b, r, z);
            issue(o, a, b, 1'b1, r, z);
            wait_idle();
        end

        // Start during a running MUL is ignored; restart in the done cycle
        issue(2'b00, 32'd3, 32'd4, 1'b1, 32'd12, 1'b0);
        e0 = cyc;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b00;
        A     = 32'd9;
        B     = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (cyc < e0 + W) begin
            @(posedge clk);
            #1;
        end
        chk("done_cycle_busy", {63'b0, busy}, 64'd0);
        issue(2'b10, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
        wait_idle();

        // Reset in the middle of a DIVU aborts it with no done pulse
        @(posedge clk);
        #1;
        issue(2'b10, 32'd100, 32'd7, 1'b0, '0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_out", {32'b0, Out}, 64'd0);
        chk("abort_dbz", {63'b0, div_by_zero}, 64'd0);
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // Reset wins over a simultaneous start
        #1;
        rst   = 1'b1;
        start = 1'b1;
        op    = 2'b00;
        A     = 32'd2;
        B     = 32'd3;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_priority_busy", {63'b0, busy}, 64'd0);
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        chk("rst_priority_no_done", 64'(done_cnt - d0), 64'd0);

        // Normal operation after reset
        #1;
        issue(2'b00, 32'd7, 32'd6, 1'b1, 32'h0000002A, 1'b0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (matches REGFILE_WIDTH).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port start  input  1  request strobe; accepted only when busy=0.
REQ-005 SHALL have port op  input  2  00 MUL (product low word), 01 MULHU (unsigned product high word), 10 DIVU (unsigned quotient), 11 REMU (unsigned remainder).
REQ-006 SHALL have port A  input  WIDTH  multiplicand / dividend.
REQ-007 SHALL have port B  input  WIDTH  multiplier / divisor.
REQ-008 SHALL have port busy  output  1  high while an operation iterates.
REQ-009 SHALL have port done  output  1  single-cycle pulse; Out and div_by_zero valid.
REQ-010 SHALL have port Out  output  WIDTH  result selected by the latched op.
REQ-011 SHALL have port div_by_zero  output  1  high with done when op is DIVU/REMU and B=0.

Function
REQ-012 SHALL implement FSM with states IDLE and RUN; done registered on the RUN->IDLE transition.
REQ-013 SHALL, on edge E0 with start=1 and busy=0, latch A, B and op, clear the iteration counter, and enter RUN (busy=1 from next cycle).
REQ-014 SHALL ignore start, A, B and op while busy=1; latched operands are not disturbed.
REQ-015 SHALL perform exactly one iteration per edge E1..E_WIDTH; counter counts 0..WIDTH-1, no wrap beyond.
REQ-016 SHALL, at edge E_WIDTH, register Out and div_by_zero, drive done=1 and busy=0 for exactly the following cycle, and return to IDLE.
REQ-017 SHALL have fixed latency WIDTH edges from start acceptance to done for every op, including divide by zero.
REQ-018 SHALL compute MUL/MULHU by shift-add on a 2*WIDTH-bit unsigned accumulator; MUL returns bits [WIDTH-1:0], MULHU bits [2*WIDTH-1:WIDTH].
REQ-019 SHALL compute DIVU/REMU by restoring division: per iteration shift remainder left by one, bringing in the next dividend MSB, trial-subtract B with a WIDTH+1-bit subtractor, and keep the difference and shift a 1 into the quotient when non-negative.
REQ-020 SHALL, for B=0 on DIVU, return Out=all-ones; on REMU, return Out=A; div_by_zero=1 in both cases.
REQ-021 SHALL hold Out and div_by_zero stable from one done pulse until the next done pulse.
REQ-022 SHALL hold div_by_zero=0 for MUL/MULHU results.
REQ-023 SHALL accept a start presented in the done cycle (busy=0), giving back-to-back operations with no idle cycle.
REQ-024 SHALL treat all arithmetic as unsigned; signed ops are out of scope.

Reset
REQ-025 SHALL, when rst=1 at any edge, enter IDLE and set busy=0, done=0, Out=0, div_by_zero=0, counter=0.
REQ-026 SHALL, when rst asserts mid-operation, abort the operation with no done pulse; rst takes priority over a simultaneous start.

Verification
REQ-027 SHALL verify MUL A=7, B=6: start at E0 -> done high in cycle after E32, Out=0x0000002A, div_by_zero=0.
REQ-028 SHALL verify MULHU A=B=0xFFFFFFFF -> Out=0xFFFFFFFE; repeated with MUL -> Out=0x00000001.
REQ-029 SHALL verify DIVU 100/7 -> Out=14; REMU 100/7 -> Out=2; DIVU 0xFFFFFFFF/1 -> Out=0xFFFFFFFF.
REQ-030 SHALL verify DIVU 5/0 -> Out=0xFFFFFFFF, div_by_zero=1; REMU 5/0 -> Out=5, div_by_zero=1, both at 32-edge latency.
REQ-031 SHALL verify that start with A=9, B=9 at E5 of a running MUL 3*4 is ignored -> done once, Out=12; a new start in the done cycle yields a second done 32 edges later.
REQ-032 SHALL verify that rst asserted at E10 of a DIVU -> busy=0, Out=0 next cycle, no done pulse within 40 cycles.
